operand_fetcher: RTL
====================

OPERAND_FETCHER -- requirements
Module: operand_fetcher

Interface
REQ-001 Parameter ADDR_W, default 10: operand SRAM word-address width.
REQ-002 Parameter ROWS_W, default 8: width of row-count field.
REQ-003 Parameter DRAIN_CYCLES, default 2*`SYS_ARRAY_LEN: idle cycles after the last row so the skew stage and systolic array can empty.
REQ-004 Port: clk  in  1  rising-edge clock.
REQ-005 Port: rst_n  in  1  active-low reset.
REQ-006 Port: start  in  1  single-cycle command strobe, sampled only in IDLE.
REQ-007 Port: base_addr  in  ADDR_W  address of row 0, sampled with start.
REQ-008 Port: stride  in  ADDR_W  address increment between rows, sampled with start.
REQ-009 Port: num_rows  in  ROWS_W  rows to fetch, sampled with start.
REQ-010 Port: hold  in  1  when high, no new read is issued this cycle.
REQ-011 Port: sram_ren  out  1  operand SRAM read enable.
REQ-012 Port: sram_addr  out  ADDR_W  operand SRAM read address.
REQ-013 Port: sram_rdata  in  `NUMBER x `SYS_ARRAY_LEN  read data, valid exactly one cycle after sram_ren.
REQ-014 Port: data_out  out  `NUMBER x `SYS_ARRAY_LEN  row vector to the skew stage (its data_in).
REQ-015 Port: data_valid  out  1  data_out carries a valid row.
REQ-016 Port: busy  out  1  high in FETCH and DRAIN.
REQ-017 Port: done  out  1  one-cycle pulse at command completion.
REQ-018 The block SHALL use one clock, clk; reset rst_n SHALL be asynchronous and active-low.

Function
REQ-019 The block SHALL implement states IDLE, FETCH, DRAIN.
REQ-020 IDLE, start=1, num_rows>0: latch base_addr/stride/num_rows, clear row counter k, enter FETCH next cycle.
REQ-021 IDLE, start=1, num_rows=0: no read issued; done SHALL pulse the next cycle; remain IDLE.
REQ-022 start while busy SHALL be ignored with no effect on the running command.
REQ-023 In FETCH, each cycle with hold=0 SHALL assert sram_ren with sram_addr = base_addr + k*stride (mod 2^ADDR_W) and increment k.
REQ-024 In FETCH with hold=1, sram_ren SHALL be 0 and k, sram_addr SHALL hold.
REQ-025 The cycle issuing row num_rows-1 SHALL be the last FETCH cycle; next state DRAIN.
REQ-026 sram_addr SHALL be computed by accumulation (addr += stride), wrapping modulo 2^ADDR_W without error.
REQ-027 data_valid SHALL equal sram_ren delayed one cycle; data_out SHALL equal sram_rdata when data_valid=1, else all-zero.
REQ-028 DRAIN SHALL last exactly DRAIN_CYCLES cycles counted from entry, then pulse done for one cycle concurrent with return to IDLE.
REQ-029 A start in the same cycle done pulses SHALL be accepted (state is IDLE that cycle).
REQ-030 busy SHALL be high from the cycle after an accepted start (num_rows>0) through the last DRAIN cycle.
REQ-031 Rows SHALL reach data_out in issue order, one per issue, never duplicated or dropped.
REQ-032 Outputs SHALL be registered; sram_ren/sram_addr SHALL not depend combinationally on hold from the same cycle beyond REQ-024 gating.

Reset
REQ-033 On rst_n=0: state IDLE, k=0, sram_ren=0, sram_addr=0, data_valid=0, data_out all-zero, busy=0, done=0.
REQ-034 Reset mid-FETCH or mid-DRAIN SHALL abort the command; a read issued in the reset cycle SHALL NOT produce data_valid after release.
REQ-035 First start SHALL be accepted on the first rising edge after rst_n deasserts.

Verification (`SYS_ARRAY_LEN=4, ADDR_W=10, DRAIN_CYCLES=8)
REQ-036 start, base=0x010, stride=4, rows=3, hold=0 -> sram_addr 0x010,0x014,0x018 on consecutive cycles; data_valid high 3 cycles one cycle later; done 8 cycles after FETCH exit.
REQ-037 Same command with hold=1 on second FETCH cycle -> addresses 0x010,(bubble),0x014,0x018; data_valid pattern 1,0,1,1.
REQ-038 start, rows=0 -> no sram_ren, done pulse next cycle, busy stays 0.
REQ-039 base=0x3FE, stride=1, rows=4 -> addresses 0x3FE,0x3FF,0x000,0x001.
REQ-040 Reset asserted on second FETCH cycle -> all outputs zero immediately; no data_valid after release; new start completes normally.
REQ-041 Second start during DRAIN ignored; start coincident with done accepted and new addresses issue next cycle.

Source files
------------

// File: rtl/operand_fetcher.sv
// Operand fetcher: issues strided SRAM row reads for the systolic array, then
// idles DRAIN_CYCLES so the skew stage and array can empty before done.
`ifndef NUMBER
`define NUMBER 16
`endif
`ifndef SYS_ARRAY_LEN
`define SYS_ARRAY_LEN 4
`endif

module operand_fetcher #(
    parameter int unsigned ADDR_W       = 10,
    parameter int unsigned ROWS_W       = 8,
    parameter int unsigned NUM_W        = `NUMBER,
    parameter int unsigned ARRAY_LEN    = `SYS_ARRAY_LEN,
    parameter int unsigned DRAIN_CYCLES = 2 * ARRAY_LEN
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [ADDR_W-1:0]          base_addr,
    input  logic [ADDR_W-1:0]          stride,
    input  logic [ROWS_W-1:0]          num_rows,
    input  logic                       hold,
    output logic                       sram_ren,
    output logic [ADDR_W-1:0]          sram_addr,
    input  logic [NUM_W*ARRAY_LEN-1:0] sram_rdata,
    output logic [NUM_W*ARRAY_LEN-1:0] data_out,
    output logic                       data_valid,
    output logic                       busy,
    output logic                       done
);

    localparam int unsigned CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   stride_q, stride_d;
    logic [ROWS_W-1:0]   rows_q, rows_d;
    logic [ROWS_W-1:0]   k_q, k_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                done_q, done_d;
    logic                dv_q;
    logic                issue;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            stride_q <= '0;
            rows_q   <= '0;
            k_q      <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            dv_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            stride_q <= stride_d;
            rows_q   <= rows_d;
            k_q      <= k_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            dv_q     <= issue;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        stride_d = stride_q;
        rows_d   = rows_q;
        k_d      = k_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        issue    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (num_rows != '0) begin
                        addr_d   = base_addr;
                        stride_d = stride;
                        rows_d   = num_rows;
                        k_d      = '0;
                        state_d  = S_FETCH;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_FETCH: begin
                // addr_q always holds the address of row k; hold only freezes it
                if (!hold) begin
                    issue  = 1'b1;
                    addr_d = addr_q + stride_q;
                    k_d    = k_q + ROWS_W'(1);
                    if (k_q == rows_q - ROWS_W'(1)) begin
                        cnt_d = '0;
                        if (DRAIN_CYCLES == 0) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = S_DRAIN;
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign sram_ren   = issue;
    assign sram_addr  = addr_q;
    assign data_valid = dv_q;
    assign data_out   = dv_q ? sram_rdata : '0;
    assign busy       = (state_q != S_IDLE);
    assign done       = done_q;

endmodule
